mult3_sequencer: RTL and testbench

Sequencer that computes the 24-bit product a*b*c of three unsigned 8-bit operands using a single instance of the team's 8x8 combinational multiplier (mult2), time-shared over three passes. It sits between an upstream operand source and a downstream result consumer, with a valid/ready handshake on each side. Each pass registers one partial product. A completed-operation counter is provided for performance monitoring.

---
 rtl/mult3_pkg.sv | 23 ++
 rtl/mult3_sequencer_mult2.sv | 12 +
 rtl/mult3_sequencer.sv | 125 ++++++++++++
 tb/tb_mult3_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult3_pkg.sv
// Shared constants, state encoding and helpers for the three-operand
// multiply sequencer.
package mult3_pkg;

    localparam int OP_W   = 8;
    localparam int PP_W   = 16;
    localparam int PROD_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        MUL_AB,
        MUL_LO,
        MUL_HI,
        DONE
    } state_t;

    function automatic logic any_zero(input logic [OP_W-1:0] x,
                                      input logic [OP_W-1:0] y,
                                      input logic [OP_W-1:0] z);
        return (x == '0) || (y == '0) || (z == '0);
    endfunction

endpackage

// File: rtl/mult3_sequencer_mult2.sv
// The team's 8x8 unsigned combinational multiplier, producing a 16-bit product.
module mult2
    import mult3_pkg::*;
(
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    output logic [PP_W-1:0] product
);

    assign product = PP_W'(op_a) * PP_W'(op_b);

endmodule

// File: rtl/mult3_sequencer.sv
// Computes a*b*c over three passes of one shared 8x8 multiplier, with
// valid/ready handshakes on both sides and a consumed-result counter.
module mult3_sequencer
    import mult3_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int ZERO_SKIP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    input  logic [OP_W-1:0]     c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   prod,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [OP_W-1:0]     c_q, c_d;
    logic [PP_W-1:0]     p_q, p_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [OP_W-1:0]     mul_a;
    logic [OP_W-1:0]     mul_b;
    logic [PP_W-1:0]     mul_p;

    mult2 u_mult2 (
        .op_a    (mul_a),
        .op_b    (mul_b),
        .product (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pass 1 forms a*b; passes 2 and 3 multiply its low and high bytes by c
    // and stitch the two 16-bit partials together in the accumulator.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mul_a   = '0;
        mul_b   = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    c_d = c;
                    if ((ZERO_SKIP != 0) && any_zero(a, b, c)) begin
                        acc_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = MUL_AB;
                    end
                end
            end
            MUL_AB: begin
                mul_a   = a_q;
                mul_b   = b_q;
                p_d     = mul_p;
                state_d = MUL_LO;
            end
            MUL_LO: begin
                mul_a   = p_q[7:0];
                mul_b   = c_q;
                acc_d   = {8'h00, mul_p};
                state_d = MUL_HI;
            end
            MUL_HI: begin
                mul_a   = p_q[15:8];
                mul_b   = c_q;
                acc_d   = acc_q + {mul_p, 8'h00};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so every output reads 0 while reset is held.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign prod      = acc_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_mult3_sequencer.sv
// Randomized self-checking bench for mult3_sequencer: three instances cover
// zero-skip on, zero-skip off and a 2-bit wrapping counter.
module tb_mult3_sequencer;

    logic clk;
    logic rst_n;

    logic        iv0, iv1, iv2;
    logic        or0, or1, or2;
    logic [7:0]  a0, b0, c0, a1, b1, c1, a2, b2, c2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        bz0, bz1, bz2;
    logic [23:0] pr0, pr1, pr2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int n_cmp;
    int n_err;
    int exp_cnt [3];
    int zs      [3];
    int cw      [3];

    mult3_sequencer #(.CNT_W(16), .ZERO_SKIP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .c(c0), .out_valid(ov0), .out_ready(or0),
        .prod(pr0), .busy(bz0), .op_count(cnt0)
    );

    mult3_sequencer #(.CNT_W(16), .ZERO_SKIP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .c(c1), .out_valid(ov1), .out_ready(or1),
        .prod(pr1), .busy(bz1), .op_count(cnt1)
    );

    mult3_sequencer #(.CNT_W(2), .ZERO_SKIP(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .c(c2), .out_valid(ov2), .out_ready(or2),
        .prod(pr2), .busy(bz2), .op_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_ir(input int s);
        case (s)
            0: return ir0;
            1: return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic get_ov(input int s);
        case (s)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_bz(input int s);
        case (s)
            0: return bz0;
            1: return bz1;
            default: return bz2;
        endcase
    endfunction

    function automatic logic [23:0] get_prod(input int s);
        case (s)
            0: return pr0;
            1: return pr1;
            default: return pr2;
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int s);
        case (s)
            0: return {16'h0, cnt0};
            1: return {16'h0, cnt1};
            default: return {30'h0, cnt2};
        endcase
    endfunction

    task automatic drive_in(input int s, input logic v, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] z);
        case (s)
            0: begin iv0 = v; a0 = x; b0 = y; c0 = z; end
            1: begin iv1 = v; a1 = x; b1 = y; c1 = z; end
            default: begin iv2 = v; a2 = x; b2 = y; c2 = z; end
        endcase
    endtask

    task automatic drive_ready(input int s, input logic r);
        case (s)
            0: or0 = r;
            1: or1 = r;
            default: or2 = r;
        endcase
    endtask

    // One full transaction: accept, wait for the result, hold off the
    // consumer for `hold` cycles, then consume and check the counter.
    task automatic applyStimulus(input int s, input logic [7:0] x,
                                 input logic [7:0] y, input logic [7:0] z,
                                 input int hold);
        int lat;
        int exp_lat;
        int exp_p;
        exp_p   = int'(x) * int'(y) * int'(z);
        exp_lat = (zs[s] != 0 && (x == 0 || y == 0 || z == 0)) ? 0 : 3;
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(get_ir(s)), 32'd1);
        drive_in(s, 1'b1, x, y, z);
        @(negedge clk);
        drive_in(s, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        lat = 0;
        while (!get_ov(s) && lat < 10) begin
            checkOutput("busy_calc", 32'(get_bz(s)), 32'd1);
            checkOutput("in_ready_calc", 32'(get_ir(s)), 32'd0);
            if (s == 0 && lat == 1)
                checkOutput("p_r", 32'(u_dut0.p_q), 32'(int'(x) * int'(y)));
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("prod", 32'(get_prod(s)), 32'(exp_p));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("prod_held", 32'(get_prod(s)), 32'(exp_p));
            checkOutput("valid_held", 32'(get_ov(s)), 32'd1);
            checkOutput("in_ready_held", 32'(get_ir(s)), 32'd0);
            checkOutput("busy_held", 32'(get_bz(s)), 32'd1);
        end
        drive_ready(s, 1'b1);
        @(negedge clk);
        drive_ready(s, 1'b0);
        exp_cnt[s] = (exp_cnt[s] + 1) % (1 << cw[s]);
        checkOutput("valid_after", 32'(get_ov(s)), 32'd0);
        checkOutput("in_ready_after", 32'(get_ir(s)), 32'd1);
        checkOutput("busy_after", 32'(get_bz(s)), 32'd0);
        checkOutput("op_count", get_cnt(s), 32'(exp_cnt[s]));
    endtask

    function automatic logic [7:0] rand_op();
        if ($urandom_range(0, 5) == 0)
            return 8'h00;
        return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        zs = '{1, 0, 1};
        cw = '{16, 16, 2};
        exp_cnt = '{0, 0, 0};
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive_in(s, 1'b0, 8'h00, 8'h00, 8'h00);
            drive_ready(s, 1'b0);
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(ov0), 32'd0);
        checkOutput("rst_prod", 32'(pr0), 32'd0);
        checkOutput("rst_busy", 32'(bz0), 32'd0);
        checkOutput("rst_in_ready", 32'(ir0), 32'd0);
        checkOutput("rst_op_count", get_cnt(0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_post_rst", 32'(ir0), 32'd1);

        $display("[TB] directed transactions");
        applyStimulus(0, 8'd3, 8'd5, 8'd7, 0);
        applyStimulus(0, 8'd255, 8'd255, 8'd255, 0);
        applyStimulus(0, 8'd0, 8'd200, 8'd9, 0);
        applyStimulus(0, 8'd2, 8'd3, 8'd4, 5);
        applyStimulus(1, 8'd0, 8'd200, 8'd9, 0);
        applyStimulus(1, 8'd3, 8'd5, 8'd7, 1);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 20; i++)
            applyStimulus(0, rand_op(), rand_op(), rand_op(), $urandom_range(0, 3));
        for (int i = 0; i < 8; i++)
            applyStimulus(1, rand_op(), rand_op(), rand_op(), $urandom_range(0, 2));

        $display("[TB] reset during MUL_LO");
        @(negedge clk);
        drive_in(0, 1'b1, 8'd7, 8'd9, 8'd11);
        @(negedge clk);
        drive_in(0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cnt = '{0, 0, 0};
        checkOutput("midrst_out_valid", 32'(ov0), 32'd0);
        checkOutput("midrst_prod", 32'(pr0), 32'd0);
        checkOutput("midrst_busy", 32'(bz0), 32'd0);
        checkOutput("midrst_in_ready", 32'(ir0), 32'd0);
        checkOutput("midrst_op_count", get_cnt(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        or0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_orphan_result", 32'(ov0), 32'd0);
        end
        or0 = 1'b0;
        checkOutput("op_count_no_orphan", get_cnt(0), 32'd0);
        applyStimulus(0, 8'd10, 8'd10, 8'd10, 0);

        $display("[TB] 2-bit counter wrap");
        for (int i = 0; i < 5; i++)
            applyStimulus(2, 8'd1, 8'd1, 8'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
